// File: rtl/secuenciador_tupla_pkg.sv
// rtl/secuenciador_tupla_pkg.sv - state encoding and default widths for the tuple sequencer
package secuenciador_tupla_pkg;

  localparam int ANCHO_DEF       = 3;
  localparam int ANCHO_PASOS_DEF = 4;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ITERA  = 2'd1,
    FIN    = 2'd2
  } estado_t;

endpackage

// File: rtl/secuenciador_tupla_contador_pasos.sv
// rtl/secuenciador_tupla_contador_pasos.sv - remaining-iteration counter with equals-one flag
module contador_pasos
  import secuenciador_tupla_pkg::*;
#(
  parameter int ANCHO_PASOS = ANCHO_PASOS_DEF
) (
  input  logic                   Reloj,
  input  logic                   Reinicio,
  input  logic                   cargar,
  input  logic                   decrementar,
  input  logic [ANCHO_PASOS-1:0] valor,
  output logic                   es_uno
);

  logic [ANCHO_PASOS-1:0] restante;

  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      restante <= '0;
    end else if (cargar) begin
      restante <= valor;
    end else if (decrementar) begin
      restante <= restante - ANCHO_PASOS'(1);
    end
  end

  assign es_uno = (restante == ANCHO_PASOS'(1));

endmodule

// File: rtl/secuenciador_tupla.sv
// rtl/secuenciador_tupla.sv - drives an external increment datapath Pasos times from Semilla
module secuenciador_tupla
  import secuenciador_tupla_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int ANCHO_PASOS = ANCHO_PASOS_DEF
) (
  input  logic                   Reloj,
  input  logic                   Reinicio,
  input  logic                   Inicio,
  input  logic [ANCHO-1:0]       Semilla,
  input  logic [ANCHO_PASOS-1:0] Pasos,
  output logic [ANCHO-1:0]       Tupla,
  input  logic [ANCHO-1:0]       Respuesta,
  input  logic                   Cy_Rta,
  output logic                   Ocupado,
  output logic                   Listo,
  output logic [ANCHO-1:0]       Resultado,
  output logic [ANCHO_PASOS-1:0] Acarreos
);

  estado_t                estado, estado_sig;
  logic                   cargar, decrementar;
  logic                   es_uno;
  logic                   pasos_cero;
  logic [ANCHO_PASOS-1:0] acarreo;
  logic [ANCHO_PASOS-1:0] acarreo_sig;

  assign pasos_cero  = (Pasos == '0);
  assign acarreo_sig = acarreo + ANCHO_PASOS'(Cy_Rta);

  contador_pasos #(
    .ANCHO_PASOS(ANCHO_PASOS)
  ) u_contador_pasos (
    .Reloj      (Reloj),
    .Reinicio   (Reinicio),
    .cargar     (cargar),
    .decrementar(decrementar),
    .valor      (Pasos),
    .es_uno     (es_uno)
  );

  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig  = estado;
    cargar      = 1'b0;
    decrementar = 1'b0;
    case (estado)
      REPOSO: begin
        if (Inicio) begin
          cargar     = 1'b1;
          estado_sig = pasos_cero ? FIN : ITERA;
        end
      end
      ITERA: begin
        decrementar = 1'b1;
        if (es_uno) begin
          estado_sig = FIN;
        end
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // Resultado/Acarreos only change on the edge entering FIN, so they hold across idle time
  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      Tupla     <= '0;
      acarreo   <= '0;
      Resultado <= '0;
      Acarreos  <= '0;
    end else if (cargar) begin
      Tupla   <= Semilla;
      acarreo <= '0;
      if (pasos_cero) begin
        Resultado <= Semilla;
        Acarreos  <= '0;
      end
    end else if (decrementar) begin
      Tupla   <= Respuesta;
      acarreo <= acarreo_sig;
      if (es_uno) begin
        Resultado <= Respuesta;
        Acarreos  <= acarreo_sig;
      end
    end
  end

  assign Ocupado = (estado != REPOSO);
  assign Listo   = (estado == FIN);

endmodule

// File: tb/tb_secuenciador_tupla.sv
// tb/tb_secuenciador_tupla.sv - directed bench with timeline model for secuenciador_tupla
module tb_secuenciador_tupla;
  import secuenciador_tupla_pkg::*;

  localparam int ANCHO       = ANCHO_DEF;
  localparam int ANCHO_PASOS = ANCHO_PASOS_DEF;
  localparam int MOD         = 1 << ANCHO;

  logic                   Reloj = 1'b0;
  logic                   Reinicio = 1'b1;
  logic                   Inicio = 1'b0;
  logic [ANCHO-1:0]       Semilla = '0;
  logic [ANCHO_PASOS-1:0] Pasos = '0;
  logic [ANCHO-1:0]       Tupla;
  logic [ANCHO-1:0]       Respuesta;
  logic                   Cy_Rta;
  logic                   Ocupado;
  logic                   Listo;
  logic [ANCHO-1:0]       Resultado;
  logic [ANCHO_PASOS-1:0] Acarreos;

  logic [ANCHO:0] suma;
  assign suma = {1'b0, Tupla} + (ANCHO+1)'(1);
  assign {Cy_Rta, Respuesta} = suma;

  secuenciador_tupla #(
    .ANCHO      (ANCHO),
    .ANCHO_PASOS(ANCHO_PASOS)
  ) dut (
    .Reloj    (Reloj),
    .Reinicio (Reinicio),
    .Inicio   (Inicio),
    .Semilla  (Semilla),
    .Pasos    (Pasos),
    .Tupla    (Tupla),
    .Respuesta(Respuesta),
    .Cy_Rta   (Cy_Rta),
    .Ocupado  (Ocupado),
    .Listo    (Listo),
    .Resultado(Resultado),
    .Acarreos (Acarreos)
  );

  always #5 Reloj = ~Reloj;

  int total = 0;
  int bad   = 0;
  int ciclo = 0;

  always @(posedge Reloj) ciclo <= ciclo + 1;

  task automatic chk(input string nombre, input int actual, input int esperado);
    total++;
    if (actual != esperado) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nombre, actual, esperado, ciclo);
    end
  endtask

  // Listo pulse log and busy-cycle counter for the directed literal checks
  typedef struct {
    int ciclo;
    int res;
    int acc;
    int tupla;
  } pulso_t;
  pulso_t pulsos[$];
  int cnt_ocup = 0;

  always @(negedge Reloj) begin
    if (Listo === 1'b1) pulsos.push_back('{ciclo, int'(Resultado), int'(Acarreos), int'(Tupla)});
    if (Ocupado === 1'b1) cnt_ocup++;
  end

  // Timeline model: a start accepted in cycle t0 is busy for t0+1..t0+p+1 and ends at (s+p) mod 2^ANCHO
  bit m_valido = 0;
  bit m_ocup   = 0;
  int m_t0, m_s, m_p;
  int m_tupla = 0, m_res = 0, m_acc = 0;

  always @(negedge Reloj) begin : modelo
    int  e_tupla;
    bit  e_listo;
    if (m_valido) begin
      e_listo = 0;
      e_tupla = m_tupla;
      if (m_ocup) begin
        e_tupla = (m_s + ciclo - m_t0 - 1) % MOD;
        if (ciclo == m_t0 + m_p + 1) begin
          e_listo = 1;
          m_res   = (m_s + m_p) % MOD;
          m_acc   = (m_s + m_p) / MOD;
        end
      end
      chk("model_tupla", int'(Tupla), e_tupla);
      chk("model_ocupado", int'(Ocupado), int'(m_ocup));
      chk("model_listo", int'(Listo), int'(e_listo));
      chk("model_resultado", int'(Resultado), m_res);
      chk("model_acarreos", int'(Acarreos), m_acc);
    end
    if (Reinicio) begin
      m_valido = 1;
      m_ocup   = 0;
      m_tupla  = 0;
      m_res    = 0;
      m_acc    = 0;
    end else if (m_valido) begin
      if (m_ocup && ciclo == m_t0 + m_p + 1) begin
        m_ocup  = 0;
        m_tupla = (m_s + m_p) % MOD;
      end else if (!m_ocup && Inicio) begin
        m_ocup = 1;
        m_t0   = ciclo;
        m_s    = int'(Semilla);
        m_p    = int'(Pasos);
      end
    end
  end

  int t0;

  task automatic iniciar(input int s, input int p);
    Inicio  = 1'b1;
    Semilla = ANCHO'(s);
    Pasos   = ANCHO_PASOS'(p);
    t0      = ciclo;
    @(posedge Reloj); #1;
    Inicio = 1'b0;
  endtask

  task automatic esperar(input int n);
    repeat (n) begin
      @(posedge Reloj); #1;
    end
  endtask

  task automatic caso(input string nombre, input int s, input int p, input int res, input int acc);
    pulsos.delete();
    cnt_ocup = 0;
    iniciar(s, p);
    esperar(p + 3);
    chk({nombre, "_pulses"}, pulsos.size(), 1);
    if (pulsos.size() >= 1) begin
      chk({nombre, "_cycle"}, pulsos[0].ciclo - t0, p + 1);
      chk({nombre, "_res"}, pulsos[0].res, res);
      chk({nombre, "_acc"}, pulsos[0].acc, acc);
    end
    chk({nombre, "_busy"}, cnt_ocup, p + 1);
  endtask

  initial begin
    esperar(3);
    Reinicio = 1'b0;
    chk("rst_tupla", int'(Tupla), 0);
    chk("rst_ocupado", int'(Ocupado), 0);
    chk("rst_listo", int'(Listo), 0);
    chk("rst_resultado", int'(Resultado), 0);
    chk("rst_acarreos", int'(Acarreos), 0);
    esperar(2);

    caso("s6p5", 6, 5, 3, 1);
    caso("s5p0", 5, 0, 5, 0);
    if (pulsos.size() >= 1) chk("s5p0_tupla", pulsos[0].tupla, 5);
    caso("s7p15", 7, 15, 6, 2);
    caso("s3p7", 3, 7, 2, 1);
    chk("hold_resultado", int'(Resultado), 2);
    chk("hold_acarreos", int'(Acarreos), 1);

    // Inicio held high: second start lands in the REPOSO cycle right after FIN
    pulsos.delete();
    Inicio  = 1'b1;
    Semilla = '0;
    Pasos   = ANCHO_PASOS'(2);
    t0      = ciclo;
    esperar(8);
    Inicio = 1'b0;
    esperar(3);
    chk("held_pulses", pulsos.size(), 2);
    if (pulsos.size() == 2) begin
      chk("held_cycle0", pulsos[0].ciclo - t0, 3);
      chk("held_cycle1", pulsos[1].ciclo - t0, 7);
      chk("held_res0", pulsos[0].res, 2);
      chk("held_res1", pulsos[1].res, 2);
    end

    // Reset in cycle 3 of a Pasos=8 run
    pulsos.delete();
    iniciar(4, 8);
    esperar(2);
    Reinicio = 1'b1;
    esperar(1);
    Reinicio = 1'b0;
    chk("abort_tupla", int'(Tupla), 0);
    chk("abort_ocupado", int'(Ocupado), 0);
    chk("abort_resultado", int'(Resultado), 0);
    chk("abort_acarreos", int'(Acarreos), 0);
    esperar(10);
    chk("abort_pulses", pulsos.size(), 0);
    caso("after_abort", 1, 3, 4, 0);

    // Reinicio wins over Inicio
    Inicio   = 1'b1;
    Reinicio = 1'b1;
    Semilla  = ANCHO'(5);
    Pasos    = ANCHO_PASOS'(3);
    esperar(1);
    Inicio   = 1'b0;
    Reinicio = 1'b0;
    chk("prio_ocupado", int'(Ocupado), 0);
    chk("prio_tupla", int'(Tupla), 0);
    esperar(3);
    chk("prio_idle", int'(Ocupado), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
